// File: rtl/palette_loader.sv
// Palette file loader: packs streamed RGB bytes into 64 palette RAM writes,
// zero-fills any entries a short file leaves unwritten, and flags oversize files.
module palette_loader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        pal_sel,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        load_color,
    output logic [23:0] load_color_data,
    output logic [5:0]  load_color_index,
    output logic        busy,
    output logic        pal_loaded,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FILL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        session;
    logic        session_q;
    logic        session_rise;
    logic [1:0]  phase_q, phase_d;
    logic [6:0]  entry_q, entry_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [7:0]  b_q, b_d;
    logic        load_color_q, load_color_d;
    logic [23:0] data_q, data_d;
    logic [5:0]  index_q, index_d;
    logic        pal_loaded_q, pal_loaded_d;
    logic        overflow_q, overflow_d;

    assign session      = ioctl_download & pal_sel;
    assign session_rise = session & ~session_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
        state_d      = state_q;
        phase_d      = phase_q;
        entry_d      = entry_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        load_color_d = 1'b0;
        data_d       = data_q;
        index_d      = index_q;
        pal_loaded_d = pal_loaded_q;
        overflow_d   = overflow_q;

        if (session_rise) begin
            state_d      = COLLECT;
            phase_d      = 2'd0;
            entry_d      = 7'd0;
            pal_loaded_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (!session) begin
                        // Trailing partial entry is dropped; the first zero-fill write issues on this edge.
                        phase_d = 2'd0;
                        if (!entry_q[6]) begin
                            state_d      = FILL;
                            load_color_d = 1'b1;
                            data_d       = 24'h000000;
                            index_d      = entry_q[5:0];
                            entry_d      = entry_q + 7'd1;
                        end else begin
                            state_d      = DONE;
                            pal_loaded_d = 1'b1;
                        end
                    end else if (ioctl_wr) begin
                        if (entry_q[6]) begin
                            overflow_d = 1'b1;
                        end else begin
                            case (phase_q)
                                2'd0: begin
                                    r_d     = ioctl_dout;
                                    phase_d = 2'd1;
                                end
                                2'd1: begin
                                    g_d     = ioctl_dout;
                                    phase_d = 2'd2;
                                end
                                default: begin
                                    b_d          = ioctl_dout;
                                    phase_d      = 2'd0;
                                    load_color_d = 1'b1;
                                    data_d       = {r_q, g_q, b_d};
                                    index_d      = entry_q[5:0];
                                    entry_d      = entry_q + 7'd1;
                                end
                            endcase
                        end
                    end
                end
                FILL: begin
                    // The entry after index 63 has been written: stop without wrapping.
                    if (entry_q[6]) begin
                        state_d      = DONE;
                        pal_loaded_d = 1'b1;
                    end else begin
                        load_color_d = 1'b1;
                        data_d       = 24'h000000;
                        index_d      = entry_q[5:0];
                        entry_d      = entry_q + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            session_q    <= 1'b0;
            phase_q      <= 2'd0;
            entry_q      <= 7'd0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            b_q          <= 8'd0;
            load_color_q <= 1'b0;
            data_q       <= 24'd0;
            index_q      <= 6'd0;
            pal_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            session_q    <= session;
            phase_q      <= phase_d;
            entry_q      <= entry_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            load_color_q <= load_color_d;
            data_q       <= data_d;
            index_q      <= index_d;
            pal_loaded_q <= pal_loaded_d;
            overflow_q   <= overflow_d;
        end
    end

    assign load_color       = load_color_q;
    assign load_color_data  = data_q;
    assign load_color_index = index_q;
    assign busy             = (state_q == COLLECT) || (state_q == FILL);
    assign pal_loaded       = pal_loaded_q;
    assign overflow         = overflow_q;

endmodule

// File: doc/palette_loader.md
PALETTE_LOADER -- requirements
Module: palette_loader

Interface
REQ-001 The block SHALL have no parameters; the palette size is fixed at 64 entries of 24 bits, RGB 8:8:8.
REQ-002 clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ioctl_download  in  1  high for the duration of a host file transfer.
REQ-005 pal_sel  in  1  high when the current transfer is a palette file; sampled together with ioctl_download.
REQ-006 ioctl_wr  in  1  single-cycle byte strobe; back-to-back strobes on consecutive cycles are legal.
REQ-007 ioctl_dout  in  8  byte data, valid when ioctl_wr is high.
REQ-008 load_color  out  1  single-cycle write strobe to the palette RAM.
REQ-009 load_color_data  out  24  entry value {R,G,B}, with R in [23:16].
REQ-010 load_color_index  out  6  palette entry address.
REQ-011 busy  out  1  high in the COLLECT and FILL states.
REQ-012 pal_loaded  out  1  high once a complete 64-entry palette has been written.
REQ-013 overflow  out  1  sticky flag: the current file exceeded 192 bytes.

Function
REQ-014 The state machine SHALL have four states: IDLE, COLLECT, FILL, DONE.
REQ-015 session = ioctl_download & pal_sel; a rising edge of session in any state SHALL do all of the following:
- clear the byte phase (0..2), the entry counter (0..64), pal_loaded and overflow;
- cancel any pending write;
- enter COLLECT.
REQ-016 In COLLECT, each ioctl_wr SHALL store ioctl_dout into the R, G or B byte selected by phase 0, 1 or 2, then advance phase, wrapping 2 to 0.
REQ-017 When the phase-2 byte is accepted on cycle N and entry<64:
- load_color SHALL be 1 on cycle N+1 only;
- load_color_index SHALL equal entry[5:0];
- load_color_data SHALL equal {R,G,B}, including the byte just received;
- entry SHALL increment.
REQ-018 Back-to-back ioctl_wr SHALL lose no bytes; the block sustains one write per three bytes at full strobe rate.
REQ-019 Once entry=64, further ioctl_wr in COLLECT SHALL set overflow=1 and produce no load_color.
REQ-020 ioctl_wr outside COLLECT, or while session is low, SHALL be ignored.
REQ-021 On a falling edge of session in COLLECT:
- any write already scheduled by REQ-017 SHALL complete first;
- a partial trailing entry (phase 1 or 2) SHALL be discarded;
- if entry<64, go to FILL; otherwise go to DONE.
REQ-022 In FILL, one write SHALL be issued per cycle: load_color=1, load_color_data=24'h000000, index=entry; entry increments; after index 63, go to DONE.
REQ-023 Entering DONE SHALL set pal_loaded=1; DONE SHALL hold until the next session rising edge.
REQ-024 When load_color is 0, load_color_data and load_color_index SHALL hold their last values.
REQ-025 load_color SHALL never be high for two writes to the same index within one session, and never high in IDLE or DONE.
REQ-026 entry SHALL be 7 bits wide; an increment beyond 64 SHALL NOT occur, so the index never wraps to 0.

Reset
REQ-027 While reset_n=0:
- the state SHALL be IDLE;
- all outputs SHALL be 0;
- phase, entry and the R, G, B holding registers SHALL be 0;
- the session edge detector SHALL be 0.
REQ-028 If session is already high when reset_n releases, that SHALL count as a rising edge on the first clock after release.
REQ-029 A reset mid-COLLECT or mid-FILL SHALL abort immediately; no pending write SHALL emerge after release.

Verification
REQ-030 Full file: 192 bytes with byte i = i, strobed back-to-back -> 64 pulses; pulse k has index k and data {3k,3k+1,3k+2}; each pulse lands one cycle after byte 3k+2; after download falls, pal_loaded=1 and overflow=0.
REQ-031 Short file: bytes FF,00,80,11,22,33,44 -> writes (0,FF0080) and (1,112233); byte 44 is discarded; then 62 consecutive FILL pulses for indices 2..63 with data 000000, with busy high throughout; then pal_loaded=1.
REQ-032 Long file: 195 bytes -> exactly 64 pulses; overflow=1 from byte 193 onward; pal_loaded=1 at the end.
REQ-033 Reset mid-COLLECT after 4 entries -> outputs go to 0 asynchronously; after release with no new session, ioctl_wr strobes produce no pulse and pal_loaded stays 0.
REQ-034 Restart during FILL: a new session rising edge at FILL index 10 -> FILL stops and entry=0; the new file writes from index 0 with no FILL pulse following.
REQ-035 Non-palette transfer: ioctl_download=1, pal_sel=0, 192 strobes -> no load_color, busy=0, and state stays IDLE.
